beat_generator_multi: RTL and testbench

//   Multi-channel programmable beat generator, successor to the fixed-STOP single beat counter.
//   NUM_CH independent counters share one clock and one global advance enable.

---
 rtl/beat_generator_multi_pkg.sv | 15 +
 rtl/beat_generator_multi_if.sv | 31 +++
 rtl/beat_generator_multi_channel.sv | 95 +++++++++
 rtl/beat_generator_multi.sv | 50 +++++
 tb/tb_beat_generator_multi.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/beat_generator_multi_pkg.sv
// Shared types and helpers for the multi-channel beat generator.
package beat_gen_pkg;

    // Channel run mode, written alongside the period.
    typedef enum logic {
        MODE_CONT    = 1'b0,
        MODE_ONESHOT = 1'b1
    } beat_mode_e;

    // Width of the channel-select field; never narrower than one bit.
    function automatic int chIdxWidth(input int numCh);
        return (numCh < 2) ? 1 : $clog2(numCh);
    endfunction

endpackage

// File: rtl/beat_generator_multi_if.sv
// Control/status bundle of the beat generator: global enable, config write
// port, per-channel start/stop strobes and the beat/busy outputs.
interface beat_generator_multi_if
    import beat_gen_pkg::*;
#(
    parameter int WIDTH  = 10,
    parameter int NUM_CH = 4
);
    localparam int CH_W = chIdxWidth(NUM_CH);

    logic              en;
    logic              wr_en;
    logic [CH_W-1:0]   wr_ch;
    logic [WIDTH-1:0]  wr_period;
    logic              wr_oneshot;
    logic [NUM_CH-1:0] start;
    logic [NUM_CH-1:0] stop;
    logic [NUM_CH-1:0] beat;
    logic [NUM_CH-1:0] busy;

    modport master (
        output en, wr_en, wr_ch, wr_period, wr_oneshot, start, stop,
        input  beat, busy
    );

    modport slave (
        input  en, wr_en, wr_ch, wr_period, wr_oneshot, start, stop,
        output beat, busy
    );

endinterface

// File: rtl/beat_generator_multi_channel.sv
// One beat channel: counter, active/shadow period and mode, busy flag and
// the registered beat pulse. Shadow values reach the active registers only
// at a wrap, a start, or immediately when the channel is idle.
module beat_channel
    import beat_gen_pkg::*;
#(
    parameter int WIDTH      = 10,
    parameter int RST_PERIOD = 999
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_wrPeriod,
    input  logic             i_wrOneshot,
    input  logic             i_start,
    input  logic             i_stop,
    output logic             o_beat,
    output logic             o_busy
);

    localparam logic [WIDTH-1:0] RST_P = WIDTH'(RST_PERIOD);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_period;
    logic [WIDTH-1:0] r_shadow;
    beat_mode_e       r_mode;
    beat_mode_e       r_shadowMode;
    logic             r_busy;
    logic             r_beat;

    logic [WIDTH-1:0] w_nextShadow;
    beat_mode_e       w_nextShadowMode;
    logic             w_wrap;

    // Shadow values as they will be after this edge, so a write in the same
    // cycle as a start or wrap is picked up directly (write-through).
    always_comb begin
        w_nextShadow     = i_load ? i_wrPeriod : r_shadow;
        w_nextShadowMode = i_load ? beat_mode_e'(i_wrOneshot) : r_shadowMode;
        w_wrap           = r_busy && i_en && (r_count == r_period);
    end

    // Channel state: stop beats start beats wrap/advance; a one-shot wrap,
    // or a wrap that switches the channel into one-shot, is the last beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count      <= '0;
            r_period     <= RST_P;
            r_shadow     <= RST_P;
            r_mode       <= MODE_CONT;
            r_shadowMode <= MODE_CONT;
            r_busy       <= 1'b1;
            r_beat       <= 1'b0;
        end else begin
            r_shadow     <= w_nextShadow;
            r_shadowMode <= w_nextShadowMode;
            if (i_stop) begin
                r_busy  <= 1'b0;
                r_count <= '0;
                r_beat  <= 1'b0;
            end else if (i_start) begin
                r_busy   <= 1'b1;
                r_count  <= '0;
                r_period <= w_nextShadow;
                r_mode   <= w_nextShadowMode;
                r_beat   <= 1'b0;
            end else if (!r_busy) begin
                r_count <= '0;
                r_beat  <= 1'b0;
                if (i_load) begin
                    r_period <= i_wrPeriod;
                    r_mode   <= beat_mode_e'(i_wrOneshot);
                end
            end else if (w_wrap) begin
                r_count  <= '0;
                r_beat   <= 1'b1;
                r_period <= w_nextShadow;
                r_mode   <= w_nextShadowMode;
                if (r_mode == MODE_ONESHOT || w_nextShadowMode == MODE_ONESHOT) begin
                    r_busy <= 1'b0;
                end
            end else if (i_en) begin
                r_count <= r_count + 1'b1;
                r_beat  <= 1'b0;
            end else begin
                r_beat <= 1'b0;
            end
        end
    end

    assign o_beat = r_beat;
    assign o_busy = r_busy;

endmodule

// File: rtl/beat_generator_multi.sv
// Multi-channel programmable beat generator: NUM_CH independent channels
// sharing clock and global enable, configured through one write port.
module beat_generator_multi
    import beat_gen_pkg::*;
#(
    parameter int WIDTH      = 10,
    parameter int NUM_CH     = 4,
    parameter int RST_PERIOD = 999
) (
    input logic                   clk,
    input logic                   reset,
    beat_generator_multi_if.slave bus
);

    localparam int CH_W = chIdxWidth(NUM_CH);

    logic [NUM_CH-1:0] w_load;
    logic [NUM_CH-1:0] w_beat;
    logic [NUM_CH-1:0] w_busy;

    // Decode the write target; an out-of-range channel matches nothing.
    always_comb begin
        w_load = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_load[i] = bus.wr_en && (bus.wr_ch == CH_W'(i));
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        beat_channel #(
            .WIDTH      (WIDTH),
            .RST_PERIOD (RST_PERIOD)
        ) u_channel (
            .clk         (clk),
            .reset       (reset),
            .i_en        (bus.en),
            .i_load      (w_load[gi]),
            .i_wrPeriod  (bus.wr_period),
            .i_wrOneshot (bus.wr_oneshot),
            .i_start     (bus.start[gi]),
            .i_stop      (bus.stop[gi]),
            .o_beat      (w_beat[gi]),
            .o_busy      (w_busy[gi])
        );
    end

    assign bus.beat = w_beat;
    assign bus.busy = w_busy;

endmodule

// File: tb/tb_beat_generator_multi.sv
// Scoreboard bench for beat_generator_multi: directed stimulus pushes the
// expected beat cycles per channel; a negedge monitor pops and compares.
module tb_beat_generator_multi;

    localparam int WIDTH  = 10;
    localparam int NUM_CH = 4;

    logic clk;
    logic resetN;
    int   cyc;
    int   compared;
    int   mismatched;
    int   expQ [NUM_CH][$];

    beat_generator_multi_if #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) bus ();

    beat_generator_multi #(
        .WIDTH      (WIDTH),
        .NUM_CH     (NUM_CH),
        .RST_PERIOD (999)
    ) dut (
        .clk   (clk),
        .reset (resetN),
        .bus   (bus)
    );

    // Free-running clock, posedges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge counter: cycle N is the one following the Nth edge after reset release.
    always @(posedge clk or negedge resetN) begin
        if (!resetN) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    // Monitor: every beat must match the front of its channel's queue; any
    // expected cycle that passes without a beat is reported as missed.
    always @(negedge clk) begin
        if (resetN) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                while (expQ[ch].size() > 0 && expQ[ch][0] < cyc) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL beat%0d_missed: no beat seen, required at cycle %0d (now %0d)",
                             ch, expQ[ch][0], cyc);
                    void'(expQ[ch].pop_front());
                end
                if (bus.beat[ch]) begin
                    compared++;
                    if (expQ[ch].size() > 0 && expQ[ch][0] == cyc) begin
                        void'(expQ[ch].pop_front());
                    end else begin
                        mismatched++;
                        $display("[TB] FAIL beat%0d_unexpected: beat at cycle %0d, next required %0d",
                                 ch, cyc, (expQ[ch].size() > 0) ? expQ[ch][0] : -1);
                    end
                end
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic stepTo(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one cycle of stimulus so it is sampled at edge number 'edgeN'.
    task automatic applyStimulus(input int edgeN,
                                 input logic wrEn, input logic [1:0] wrCh,
                                 input logic [WIDTH-1:0] wrPeriod, input logic wrOneshot,
                                 input logic [NUM_CH-1:0] startV, input logic [NUM_CH-1:0] stopV);
        stepTo(edgeN - 1);
        bus.wr_en      = wrEn;
        bus.wr_ch      = wrCh;
        bus.wr_period  = wrPeriod;
        bus.wr_oneshot = wrOneshot;
        bus.start      = startV;
        bus.stop       = stopV;
        @(posedge clk);
        #1;
        bus.wr_en      = 1'b0;
        bus.wr_ch      = '0;
        bus.wr_period  = '0;
        bus.wr_oneshot = 1'b0;
        bus.start      = '0;
        bus.stop       = '0;
    endtask

    task automatic checkOutput(input string name, input logic [NUM_CH-1:0] actual,
                               input logic [NUM_CH-1:0] required);
        compared++;
        if (actual !== required) begin
            mismatched++;
            $display("[TB] FAIL %s: got %b, required %b (cycle %0d)", name, actual, required, cyc);
        end
    endtask

    initial begin
        compared       = 0;
        mismatched     = 0;
        resetN         = 1'b0;
        bus.en         = 1'b1;
        bus.wr_en      = 1'b0;
        bus.wr_ch      = '0;
        bus.wr_period  = '0;
        bus.wr_oneshot = 1'b0;
        bus.start      = '0;
        bus.stop       = '0;

        #12;
        checkOutput("reset_beat", bus.beat, 4'b0000);
        checkOutput("reset_busy", bus.busy, 4'b1111);
        #10 resetN = 1'b1;

        // Default period 999 on every channel; ch1 gets P=4 written at count 500.
        for (int k = 1; k <= 3; k++) begin
            expQ[0].push_back(1000 * k);
            expQ[2].push_back(1000 * k);
            expQ[3].push_back(1000 * k);
        end
        for (int c = 1000; c <= 3000; c += 5) expQ[1].push_back(c);

        stepTo(10);
        checkOutput("busy_run_10", bus.busy, 4'b1111);
        applyStimulus(501, 1'b1, 2'd1, 10'd4, 1'b0, 4'b0000, 4'b0000);
        stepTo(1500);
        checkOutput("busy_run_1500", bus.busy, 4'b1111);
        stepTo(3000);
        checkOutput("busy_run_3000", bus.busy, 4'b1111);

        // Stop ch0/1/3, write ch2 P=2 one-shot, then arm it twice.
        applyStimulus(3001, 1'b1, 2'd2, 10'd2, 1'b1, 4'b0000, 4'b1011);
        checkOutput("busy_after_stop", bus.busy, 4'b0100);
        expQ[2].push_back(3005);
        expQ[2].push_back(3013);
        applyStimulus(3002, 1'b0, 2'd0, 10'd0, 1'b0, 4'b0100, 4'b0000);
        stepTo(3004);
        checkOutput("oneshot_busy_armed", bus.busy, 4'b0100);
        stepTo(3005);
        checkOutput("oneshot_busy_fall", bus.busy, 4'b0000);
        applyStimulus(3010, 1'b0, 2'd0, 10'd0, 1'b0, 4'b0100, 4'b0000);
        stepTo(3012);
        checkOutput("oneshot2_busy_armed", bus.busy, 4'b0100);
        stepTo(3013);
        checkOutput("oneshot2_busy_fall", bus.busy, 4'b0000);

        // ch3 P=3 with en toggling every cycle: beat every 8 clocks.
        applyStimulus(3020, 1'b1, 2'd3, 10'd3, 1'b0, 4'b0000, 4'b0000);
        applyStimulus(3021, 1'b0, 2'd0, 10'd0, 1'b0, 4'b1000, 4'b0000);
        for (int c = 3028; c <= 3052; c += 8) expQ[3].push_back(c);
        for (int e = 3022; e <= 3053; e++) begin
            stepTo(e - 1);
            bus.en = ((e % 2) == 0);
        end
        stepTo(3053);
        bus.en = 1'b1;
        applyStimulus(3054, 1'b0, 2'd0, 10'd0, 1'b0, 4'b0000, 4'b1000);

        // Start+stop on ch0 (stop wins); write P=7 with start on ch1 (write-through).
        expQ[1].push_back(3068);
        applyStimulus(3060, 1'b1, 2'd1, 10'd7, 1'b0, 4'b0011, 4'b0001);
        checkOutput("start_stop_busy", bus.busy, 4'b0010);
        applyStimulus(3070, 1'b0, 2'd0, 10'd0, 1'b0, 4'b0000, 4'b0010);
        checkOutput("ch1_stopped_busy", bus.busy, 4'b0000);

        // ch0 counts up to 37 while ch1 runs P=0, then reset mid-cycle.
        applyStimulus(3080, 1'b0, 2'd0, 10'd0, 1'b0, 4'b0001, 4'b0000);
        for (int c = 3082; c <= 3117; c++) expQ[1].push_back(c);
        applyStimulus(3081, 1'b1, 2'd1, 10'd0, 1'b0, 4'b0010, 4'b0000);
        stepTo(3117);
        #6 resetN = 1'b0;
        #1;
        checkOutput("async_reset_beat", bus.beat, 4'b0000);
        checkOutput("async_reset_busy", bus.busy, 4'b1111);
        #20 resetN = 1'b1;
        for (int ch = 0; ch < NUM_CH; ch++) expQ[ch].push_back(1000);
        stepTo(999);
        checkOutput("restart_busy", bus.busy, 4'b1111);
        stepTo(1003);

        for (int ch = 0; ch < NUM_CH; ch++) begin
            compared++;
            if (expQ[ch].size() != 0) begin
                mismatched++;
                $display("[TB] FAIL beat%0d_leftover: %0d expected beats never seen, required 0",
                         ch, expQ[ch].size());
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
